dram_burst_ctrl: RTL
====================

Name: dram_burst_ctrl

Overview:
- Parametrised DRAM command sequencer. It sits between the DRAM AXI slave FSM (simple request/beat interface) and the top-level DRAM pins.
- Successor to the fixed single-beat DRAM FSM. Adds configurable timing, bursts up to MAX_LEN beats, per-beat byte strobes, read back-pressure and an optional open-page row policy.

Parameters:
- DATA_W, 32, DRAM data / beat width (bytes = DATA_W/8, WEn width).
- ROW_W, 11, row address bits.
- COL_W, 10, column address bits (≤ DRAM_A_W).
- DRAM_A_W, 11, DRAM_A width (≥ ROW_W).
- MAX_LEN, 16, max beats per burst (power of 2).
- T_RCD, 5, cycles from ACT to first column command.
- T_RP, 5, cycles from PRE to ACT.
- T_CCD, 2, min cycles between column commands.
- T_WR, 3, cycles from last write command to wr_done/PRE.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous reset, active-high.
- req_valid  in  1  burst request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ROW_W+COL_W+2  byte address; [1:0] ignored.
- req_len  in  $clog2(MAX_LEN)  beats minus 1 (AXI LEN style).
- wdata  in  DATA_W  write beat.
- wstrb  in  DATA_W/8  byte strobes, 1=write byte.
- wvalid  in  1  write beat valid.
- wready  out  1  write beat consumed.
- rdata  out  DATA_W  read beat.
- rvalid  out  1  read beat valid, held until rready.
- rlast  out  1  final read beat.
- rready  in  1  read beat accepted.
- wr_done  out  1  one-cycle pulse, write burst retired.
- idle  out  1  FSM in IDLE.
- DRAM_Q  in  DATA_W  DRAM read data.
- DRAM_valid  in  1  DRAM_Q valid.
- DRAM_CSn  out  1  chip select, low while not IDLE.
- DRAM_WEn  out  DATA_W/8  active-low byte write enables.
- DRAM_RASn  out  1  row strobe.
- DRAM_CASn  out  1  column strobe.
- DRAM_A  out  DRAM_A_W  row/column address.
- DRAM_D  out  DATA_W  write data.

Behaviour:
- Reset values: req_ready=0, wready=0, rvalid=0, rlast=0, rdata=0, wr_done=0, idle=1, DRAM_CSn=1, DRAM_WEn=all 1, DRAM_RASn=1, DRAM_CASn=1, DRAM_A=0, DRAM_D=0. Row-open flag cleared, state=IDLE.
- Reset mid-burst aborts the burst immediately. No beats are emitted after reset.
- Address split: col=req_addr[COL_W+1:2], row=req_addr[ROW_W+COL_W+1:COL_W+2]. Both are latched on acceptance.
- Column increments per beat modulo 2^COL_W, wrapping within the same row. No row change occurs during a burst.
- req_ready=1 only in IDLE. Accepting a request moves the FSM out of IDLE the next cycle.
- Commands are single-cycle pulses; DRAM_A is valid in the same cycle.
  - ACT: RASn=0, CASn=1, WEn=all 1, A=row (zero-extended).
  - PRE: RASn=0, CASn=1, WEn=all 0.
  - RD: CASn=0, RASn=1, WEn=all 1, A=col.
  - WR: CASn=0, RASn=1, WEn=~wstrb, A=col, D=wdata.
- States and transitions:
  - IDLE→ACT.
  - PRE→(T_RP)→ACT.
  - ACT→(T_RCD)→RD_CMD or WR_CMD.
  - RD_CMD→RD_WAIT. RD_WAIT captures DRAM_Q into rdata on DRAM_valid and asserts rvalid.
  - RD_WAIT→RD_HOLD. On rvalid&rready: next RD_CMD (spacing ≥T_CCD from the previous RD) or CLOSE after the last beat.
  - WR_CMD issues only while wvalid=1. wready=1 in exactly the cycle the WR command issues. After the last beat: WR_REC (T_WR)→CLOSE.
  - CLOSE: issue PRE, clear row-open flag, wait T_RP, →IDLE.
  - wr_done pulses on WR_REC exit.
- rlast=1 with the beat whose index equals the latched req_len.
- Timing counters are width $clog2(max timing)+1 and load T−1; the first follow-on command issues exactly T cycles after the previous command.
- wvalid low stalls WR_CMD indefinitely. rready low stalls indefinitely. No timeout.
- DRAM_valid outside RD_WAIT is ignored.
- req_len=0 gives a single-beat burst with rlast on that beat.

Optional Feature:
- Macro DRAM_OPEN_PAGE_EN.
- Defined: CLOSE is skipped and the row stays open, with the row-open flag and open_row register retained.
  - Next request, row hit: IDLE→column command directly, with no ACT.
  - Next request, row miss: IDLE→PRE→(T_RP)→ACT.
  - Reset closes the row logically by clearing the flag.
- Undefined: close-page behaviour as above, with ACT on every request.

Test Plan:
- Read req addr=0x0000_1008, len=0, DRAM returns 0xDEADBEEF: ACT A=row 0x001, RD A=col 0x002 exactly T_RCD=5 cycles later, rdata=0xDEADBEEF, rvalid&rlast, then PRE, idle=1.
- Write len=3, wstrb=4'b0011 on beat 2: four WR commands ≥2 cycles apart, beat-2 WEn=4'b1100, wr_done one pulse 3 cycles after the last WR.
- Read len=15 with rready low for 4 cycles on beat 7: rvalid/rdata held stable, no RD issued until accepted, rlast on beat 15 only.
- Burst at col 0x3FE, len=3: columns 0x3FE,0x3FF,0x000,0x001 with no extra ACT.
- Assert ARESET during beat 2 of a len=7 write: all DRAM strobes 1, CSn=1, idle=1 immediately, no wr_done.
- DRAM_OPEN_PAGE_EN: two reads to row 5 then one to row 9. The second read issues no ACT. The third issues PRE, ACT row 9 after T_RP, then RD.

Source files
------------

// File: rtl/dram_burst_ctrl.sv
// Burst DRAM command sequencer: ACT / RD / WR / PRE with programmable timing and per-beat strobes.
// Define DRAM_OPEN_PAGE_EN to keep the row open between requests (open-page policy).
module dram_burst_ctrl #(
   parameter int DATA_W   = 32,
   parameter int ROW_W    = 11,
   parameter int COL_W    = 10,
   parameter int DRAM_A_W = 11,
   parameter int MAX_LEN  = 16,
   parameter int T_RCD    = 5,
   parameter int T_RP     = 5,
   parameter int T_CCD    = 2,
   parameter int T_WR     = 3
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [ROW_W+COL_W+1:0]       req_addr,
   input  logic [$clog2(MAX_LEN)-1:0]   req_len,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [DATA_W-1:0]            rdata,
   output logic                         rvalid,
   output logic                         rlast,
   input  logic                         rready,
   output logic                         wr_done,
   output logic                         idle,
   input  logic [DATA_W-1:0]            DRAM_Q,
   input  logic                         DRAM_valid,
   output logic                         DRAM_CSn,
   output logic [DATA_W/8-1:0]          DRAM_WEn,
   output logic                         DRAM_RASn,
   output logic                         DRAM_CASn,
   output logic [DRAM_A_W-1:0]          DRAM_A,
   output logic [DATA_W-1:0]            DRAM_D
);

   localparam int LEN_W = $clog2(MAX_LEN);
   localparam int T_M1  = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int T_M2  = (T_CCD > T_WR) ? T_CCD : T_WR;
   localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
   localparam int CNT_W = $clog2(T_MAX) + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_ACT, S_RD_CMD, S_RD_WAIT, S_RD_HOLD,
      S_WR_CMD, S_WR_REC, S_CLOSE, S_CLOSE_WAIT
   } state_t;

`ifdef DRAM_OPEN_PAGE_EN
   localparam state_t S_END = S_IDLE;
`else
   localparam state_t S_END = S_CLOSE;
`endif

   state_t             r_state, w_state_next;
   logic               r_out_en;
   logic               r_write;
   logic [ROW_W-1:0]   r_row;
   logic [COL_W-1:0]   r_col;
   logic [LEN_W-1:0]   r_len, r_beat;
   logic [CNT_W-1:0]   r_wait;
   logic [DATA_W-1:0]  r_rdata;
   logic               r_rvalid, r_rlast;

   logic               w_accept, w_wait_done, w_last;
   logic               w_cmd_act, w_cmd_pre, w_cmd_rd, w_cmd_wr;
   logic [ROW_W-1:0]   w_req_row;
   logic [COL_W-1:0]   w_req_col;
   logic               w_unused_addr;

   assign w_req_row     = req_addr[ROW_W+COL_W+1:COL_W+2];
   assign w_req_col     = req_addr[COL_W+1:2];
   assign w_unused_addr = ^req_addr[1:0];
   assign w_accept      = (r_state == S_IDLE) && r_out_en && req_valid;
   assign w_wait_done   = (r_wait == '0);
   assign w_last        = (r_beat == r_len);

   assign rdata  = r_rdata;
   assign rvalid = r_rvalid;
   assign rlast  = r_rlast;

`ifdef DRAM_OPEN_PAGE_EN
   // r_row doubles as the open-row register; it is only overwritten on acceptance.
   logic r_row_open;
   logic w_row_hit;
   assign w_row_hit = r_row_open && (w_req_row == r_row);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)         r_row_open <= 1'b0;
      else if (w_cmd_act) r_row_open <= 1'b1;
      else if (w_cmd_pre) r_row_open <= 1'b0;
   end
`endif

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
`ifdef DRAM_OPEN_PAGE_EN
               if (!r_row_open)    w_state_next = S_ACT;
               else if (w_row_hit) w_state_next = req_write ? S_WR_CMD : S_RD_CMD;
               else                w_state_next = S_PRE;
`else
               w_state_next = S_ACT;
`endif
            end
         end
         S_PRE:        if (w_wait_done) w_state_next = S_ACT;
         S_ACT:        if (w_wait_done) w_state_next = r_write ? S_WR_CMD : S_RD_CMD;
         S_RD_CMD:     if (w_wait_done) w_state_next = S_RD_WAIT;
         S_RD_WAIT:    if (DRAM_valid)  w_state_next = S_RD_HOLD;
         S_RD_HOLD:    if (rready)      w_state_next = w_last ? S_END : S_RD_CMD;
         S_WR_CMD:     if (w_wait_done && wvalid && w_last) w_state_next = S_WR_REC;
         S_WR_REC:     if (w_wait_done) w_state_next = S_END;
         S_CLOSE:      if (w_wait_done) w_state_next = S_CLOSE_WAIT;
         S_CLOSE_WAIT: if (w_wait_done) w_state_next = S_IDLE;
         default:      w_state_next = S_IDLE;
      endcase
   end

   // Each command state fires its pin pattern in the first cycle its spacing counter reads zero.
   always_comb begin
      req_ready = 1'b0;
      wready    = 1'b0;
      wr_done   = 1'b0;
      idle      = 1'b0;
      DRAM_CSn  = 1'b0;
      DRAM_RASn = 1'b1;
      DRAM_CASn = 1'b1;
      DRAM_WEn  = '1;
      DRAM_A    = '0;
      DRAM_D    = '0;
      w_cmd_act = 1'b0;
      w_cmd_pre = 1'b0;
      w_cmd_rd  = 1'b0;
      w_cmd_wr  = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = r_out_en;
            idle      = 1'b1;
            DRAM_CSn  = 1'b1;
         end
         S_PRE, S_CLOSE: begin
            if (w_wait_done) begin
               w_cmd_pre = 1'b1;
               DRAM_RASn = 1'b0;
               DRAM_WEn  = '0;
            end
         end
         S_ACT: begin
            if (w_wait_done) begin
               w_cmd_act = 1'b1;
               DRAM_RASn = 1'b0;
               DRAM_A    = DRAM_A_W'(r_row);
            end
         end
         S_RD_CMD: begin
            if (w_wait_done) begin
               w_cmd_rd  = 1'b1;
               DRAM_CASn = 1'b0;
               DRAM_A    = DRAM_A_W'(r_col);
            end
         end
         S_WR_CMD: begin
            if (w_wait_done && wvalid) begin
               w_cmd_wr  = 1'b1;
               wready    = 1'b1;
               DRAM_CASn = 1'b0;
               DRAM_WEn  = ~wstrb;
               DRAM_A    = DRAM_A_W'(r_col);
               DRAM_D    = wdata;
            end
         end
         S_WR_REC: wr_done = w_wait_done;
         default: ;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_out_en <= 1'b0;
         r_write  <= 1'b0;
         r_row    <= '0;
         r_col    <= '0;
         r_len    <= '0;
         r_beat   <= '0;
         r_wait   <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_rlast  <= 1'b0;
      end else begin
         r_out_en <= 1'b1;
         if (!w_wait_done) r_wait <= r_wait - CNT_W'(1);
         if (w_accept) begin
            r_write <= req_write;
            r_row   <= w_req_row;
            r_col   <= w_req_col;
            r_len   <= req_len;
            r_beat  <= '0;
         end
         if (w_cmd_act) r_wait <= CNT_W'(T_RCD - 1);
         if (w_cmd_pre) r_wait <= CNT_W'(T_RP - 1);
         if (w_cmd_rd)  r_wait <= CNT_W'(T_CCD - 1);
         if (w_cmd_wr) begin
            r_wait <= w_last ? CNT_W'(T_WR - 1) : CNT_W'(T_CCD - 1);
            if (!w_last) begin
               r_beat <= r_beat + LEN_W'(1);
               r_col  <= r_col + COL_W'(1);
            end
         end
         if ((r_state == S_RD_WAIT) && DRAM_valid) begin
            r_rdata  <= DRAM_Q;
            r_rvalid <= 1'b1;
            r_rlast  <= w_last;
         end
         if ((r_state == S_RD_HOLD) && rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (!w_last) begin
               r_beat <= r_beat + LEN_W'(1);
               r_col  <= r_col + COL_W'(1);
            end
         end
      end
   end

endmodule
